dvp_pattern_gen: RTL and testbench

DVP_PATTERN_GEN -- requirements
Module: dvp_pattern_gen

---
 rtl/dvp_pattern_gen_if.sv | 12 +
 rtl/dvp_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_dvp_pattern_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_gen_if.sv
// DVP output bus: frame sync, line valid, pixel byte and end-of-frame pulse.
//   master : driven by the pattern generator
//   slave  : consumed by a sink or monitor
interface dvp_pattern_gen_if;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;

    modport master (output vsync, output href, output data, output frame_done);
    modport slave  (input  vsync, input  href, input  data, input  frame_done);
endinterface

// File: rtl/dvp_pattern_gen.sv
// DVP camera emulator: generates vsync/href/data frames carrying one of four
// RGB565 test patterns, high byte first, one byte per clk (emulated pclk).
//   clk         : pixel clock
//   rst         : synchronous active-high reset
//   enable      : start / continue frame generation (checked at frame boundary)
//   pattern     : 0 colour bars, 1 gradient, 2 solid, 3 checker
//   solid_color : RGB565 value for pattern 2
//   dvp         : vsync, href, data, frame_done (all registered)
module dvp_pattern_gen #(
    parameter int unsigned H_ACT   = 1280,
    parameter int unsigned V_ACT   = 720,
    parameter int unsigned H_BLANK = 256,
    parameter int unsigned V_SYNC  = 4,
    parameter int unsigned V_BACK  = 16,
    parameter int unsigned V_FRONT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         pattern,
    input  logic [15:0]        solid_color,
    dvp_pattern_gen_if.master  dvp
);

    localparam int unsigned LINE_LEN = 2 * H_ACT + H_BLANK;
    localparam int unsigned HREF_LEN = 2 * H_ACT;
    localparam int unsigned BAR_W    = H_ACT / 8;
    localparam int unsigned V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int unsigned V_MAX_B  = (V_ACT > V_FRONT) ? V_ACT : V_FRONT;
    localparam int unsigned V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int unsigned HCW      = $clog2(LINE_LEN);
    localparam int unsigned VCW      = $clog2(V_MAX + 1);
    localparam int unsigned XW       = ($clog2(H_ACT) > 6) ? $clog2(H_ACT) : 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        BACK   = 3'd2,
        ACTIVE = 3'd3,
        FRONT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic [VCW-1:0]   vcnt_q, vcnt_d;
    logic [1:0]       pat_q;
    logic [15:0]      solid_q;

    logic             vsync_d, href_d, frame_done_d;
    logic [7:0]       data_d;

    // Number of lines spent in each non-idle state.
    function automatic int unsigned lines_for(input state_t s);
        case (s)
            SYNC:    return V_SYNC;
            BACK:    return V_BACK;
            ACTIVE:  return V_ACT;
            FRONT:   return V_FRONT;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // State, counters and per-frame pattern latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pat_q   <= '0;
            solid_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            if (state_d == SYNC && state_q != SYNC) begin
                pat_q   <= pattern;
                solid_q <= solid_color;
            end
        end
    end

    // Next state and counters; vcnt restarts at every state change.
    always_comb begin
        logic line_end;
        logic last_line;
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        line_end  = (hcnt_q == HCW'(LINE_LEN - 1));
        last_line = (vcnt_q == VCW'(lines_for(state_q) - 1));
        if (state_q == IDLE) begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (enable) state_d = SYNC;
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + HCW'(1);
            if (line_end) begin
                if (last_line) begin
                    vcnt_d = '0;
                    case (state_q)
                        SYNC:    state_d = BACK;
                        BACK:    state_d = ACTIVE;
                        ACTIVE:  state_d = FRONT;
                        FRONT:   state_d = enable ? SYNC : IDLE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    vcnt_d = vcnt_q + VCW'(1);
                end
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the cycle that state/counters describe.
    always_comb begin
        logic [XW-1:0] x;
        logic          y3;
        logic [2:0]    bar;
        logic [15:0]   pix;
        x            = XW'(hcnt_d >> 1);
        y3           = 1'(32'(vcnt_d) >> 3);
        bar          = 3'(32'(x) / BAR_W);
        pix          = 16'h0000;
        vsync_d      = (state_d == SYNC);
        href_d       = (state_d == ACTIVE) && (hcnt_d < HCW'(HREF_LEN));
        frame_done_d = (state_d == FRONT) && (hcnt_d == HCW'(LINE_LEN - 1))
                       && (vcnt_d == VCW'(V_FRONT - 1));
        case (pat_q)
            2'd0:    pix = bar_color(bar);
            2'd1:    pix = {x[4:0], x[5:0], x[4:0]};
            2'd2:    pix = solid_q;
            default: pix = (x[3] ^ y3) ? 16'hFFFF : 16'h0000;
        endcase
        data_d = href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvp.vsync      <= 1'b0;
            dvp.href       <= 1'b0;
            dvp.data       <= 8'h00;
            dvp.frame_done <= 1'b0;
        end else begin
            dvp.vsync      <= vsync_d;
            dvp.href       <= href_d;
            dvp.data       <= data_d;
            dvp.frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Directed bench for dvp_pattern_gen with a small 16x4 frame (L=36, 288 cycles).
module tb_dvp_pattern_gen;

    localparam int FRAME     = 288;
    localparam int LINE      = 36;
    localparam int SYNC_END  = 72;
    localparam int ACT_START = 108;
    localparam int ACT_END   = 252;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern;
    logic [15:0] solid_color;

    always #5 clk = ~clk;

    dvp_pattern_gen_if bus ();

    dvp_pattern_gen #(
        .H_ACT(16), .V_ACT(4), .H_BLANK(4), .V_SYNC(2), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .solid_color(solid_color), .dvp(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] cap_data [0:FRAME-1];
    logic [7:0] bar_exp  [0:9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_pix(input logic [1:0] p, input logic [15:0] s,
                                            input int x, input int y);
        logic [5:0] xv;
        xv = 6'(x);
        case (p)
            2'd0: begin
                case (x / 2)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1:    return {xv[4:0], xv, xv[4:0]};
            2'd2:    return s;
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic logic exp_href(input int k);
        if (k < ACT_START || k >= ACT_END) return 1'b0;
        return ((k - ACT_START) % LINE) < 32;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [1:0] p, input logic [15:0] s, input int k);
        int h;
        logic [15:0] pix;
        if (!exp_href(k)) return 8'h00;
        h   = (k - ACT_START) % LINE;
        pix = exp_pix(p, s, h / 2, (k - ACT_START) / LINE);
        return (h % 2 == 1) ? pix[7:0] : pix[15:8];
    endfunction

    // Samples n cycles of a frame (k=0 is the first SYNC cycle), applying new
    // inputs after sample chg_k, and compares against the expected frame.
    task automatic run_frame(input string tag, input int n, input int chg_k,
                             input logic [1:0] cp, input logic [15:0] cs, input logic ce,
                             input logic [1:0] mp, input logic [15:0] ms);
        int ev = 0, eh = 0, ed = 0, ef = 0;
        for (int k = 0; k < n; k++) begin
            cap_data[k] = bus.data;
            if (bus.vsync !== (k < SYNC_END)) ev++;
            if (bus.href !== exp_href(k)) eh++;
            if (bus.data !== exp_byte(mp, ms, k)) ed++;
            if (bus.frame_done !== (k == FRAME - 1)) ef++;
            if (k == chg_k) begin
                pattern     = cp;
                solid_color = cs;
                enable      = ce;
            end
            step();
        end
        check({tag, "_vsync_errs"}, 32'(ev), 0);
        check({tag, "_href_errs"}, 32'(eh), 0);
        check({tag, "_data_errs"}, 32'(ed), 0);
        check({tag, "_done_errs"}, 32'(ef), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pattern = 2'd0; solid_color = 16'h0000;
        repeat (3) step();
        check("rst_vsync", 32'(bus.vsync), 0);
        check("rst_href", 32'(bus.href), 0);
        check("rst_data", 32'(bus.data), 0);
        check("rst_done", 32'(bus.frame_done), 0);
        rst = 1'b0;
        repeat (5) step();
        check("idle_vsync", 32'(bus.vsync), 0);
        check("idle_href", 32'(bus.href), 0);

        // Frame 1: bars; mid-frame pattern/colour change must not show.
        enable = 1'b1;
        step();
        run_frame("f1_bars", FRAME, 150, 2'd2, 16'hA5C3, 1'b1, 2'd0, 16'h0000);
        for (int i = 0; i < 10; i++)
            check($sformatf("bar_byte%0d", i), 32'(cap_data[ACT_START + i]), 32'(bar_exp[i]));

        // Frame 2: solid A5C3, back-to-back; change to 1234 mid-frame.
        check("b2b_vsync", 32'(bus.vsync), 1);
        run_frame("f2_solid", FRAME, 150, 2'd2, 16'h1234, 1'b1, 2'd2, 16'hA5C3);
        check("solid_hi", 32'(cap_data[ACT_START]), 32'h A5);
        check("solid_lo", 32'(cap_data[ACT_START + 1]), 32'hC3);
        check("solid_blank", 32'(cap_data[ACT_START + 32]), 0);

        // Frame 3: new colour takes effect; request checker for next frame.
        check("b2b_vsync2", 32'(bus.vsync), 1);
        run_frame("f3_solid", FRAME, 150, 2'd3, 16'h1234, 1'b1, 2'd2, 16'h1234);
        check("solid2_hi", 32'(cap_data[ACT_START]), 32'h12);
        check("solid2_lo", 32'(cap_data[ACT_START + 1]), 32'h34);

        // Frame 4: checker; enable dropped at active line 1.
        run_frame("f4_checker", FRAME, ACT_START + LINE, 2'd3, 16'h1234, 1'b0, 2'd3, 16'h1234);
        check("chk_x0", 32'(cap_data[ACT_START]), 32'h00);
        check("chk_x7", 32'(cap_data[ACT_START + 15]), 32'h00);
        check("chk_x8", 32'(cap_data[ACT_START + 16]), 32'hFF);
        check("stop_vsync", 32'(bus.vsync), 0);
        repeat (10) step();
        check("stop_idle_vsync", 32'(bus.vsync), 0);
        check("stop_idle_href", 32'(bus.href), 0);

        // Gradient partial frame, then reset in ACTIVE.
        pattern = 2'd1;
        enable  = 1'b1;
        step();
        run_frame("f5_grad", 120, -1, 2'd1, 16'h0000, 1'b1, 2'd1, 16'h0000);
        check("grad_x5_hi", 32'(cap_data[ACT_START + 10]), 32'h28);
        check("grad_x5_lo", 32'(cap_data[ACT_START + 11]), 32'hA5);
        check("pre_rst_href", 32'(bus.href), 1);
        rst = 1'b1;
        step();
        check("mid_rst_vsync", 32'(bus.vsync), 0);
        check("mid_rst_href", 32'(bus.href), 0);
        check("mid_rst_data", 32'(bus.data), 0);
        check("mid_rst_done", 32'(bus.frame_done), 0);
        rst    = 1'b0;
        enable = 1'b0;
        repeat (5) step();
        check("post_rst_vsync", 32'(bus.vsync), 0);
        check("post_rst_href", 32'(bus.href), 0);
        enable = 1'b1;
        step();
        check("restart_vsync", 32'(bus.vsync), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
